// File: rtl/pkt_gen_pkg.sv
// Shared types and constants for the test-packet generator: FSM states,
// payload modes, framing sizes, LFSR parameters and the MAC OUI.
package pkt_gen_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        HEADER  = 2'd2,
        PAYLOAD = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_ONES = 2'd0,
        MODE_INCR = 2'd1,
        MODE_LFSR = 2'd2,
        MODE_TAG  = 2'd3
    } mode_t;

    localparam int HDR_WORDS   = 6;
    localparam int BLOCK_WORDS = 8;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;

    localparam logic [39:0] MAC_OUI = 40'h02_00_00_00_00;

    // Right-shifting Galois form: the shifted-out bit folds the tap mask back in.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/pkt_gen_stream_meta_fifo.sv
// Descriptor FIFO: extra-MSB pointers, registered level/ready, RAM storage.
module meta_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_ready,
    output logic             o_empty,
    output logic [AW:0]      o_level
);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] r_level;
    logic        r_ready;
    logic [AW:0] w_wr_nxt;
    logic [AW:0] w_rd_nxt;
    logic        w_push;
    logic        w_pop;
    logic        w_full_nxt;

    // A push while full is dropped here, so the pointers can never overrun.
    assign w_push   = i_push && r_ready;
    assign w_pop    = i_pop && !o_empty;
    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_wr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push};
    assign w_rd_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};
    assign w_full_nxt = (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                        (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_level  <= w_wr_nxt - w_rd_nxt;
            r_ready  <= !w_full_nxt;
        end
    end

    simple_dual_port_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (i_data),
        .i_rd_en   (w_pop),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (o_data)
    );

    assign o_ready = r_ready;
    assign o_level = r_level;

endmodule

// File: rtl/port_to_mac.sv
// Maps a switch port number to its locally administered test MAC address.
module port_to_mac
    import pkt_gen_pkg::*;
#(
    parameter int PORT_W = 2
) (
    input  logic [PORT_W-1:0] i_port,
    output logic [47:0]       o_mac
);

    assign o_mac = {MAC_OUI, 8'(i_port)};

endmodule

// File: rtl/simple_dual_port_mem.sv
// Generic one-write / one-read synchronous RAM with a registered read port.
module simple_dual_port_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // NOTE: storage has no reset; validity is tracked by the owner's pointers,
    // which lets the array map onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pkt_gen_stream.sv
// Test-packet generator: pops descriptors from meta_fifo and streams each
// packet as a 6-word header plus a mode-selected payload over valid/ready.
module pkt_gen_stream
    import pkt_gen_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int LEN_W      = 6,
    parameter int TAG_W      = 16,
    parameter int META_DEPTH = 1024,
    parameter int DATA_WIDTH = 32,
    localparam int PORT_W     = $clog2(NUM_PORTS),
    localparam int META_WIDTH = 2*PORT_W + LEN_W + TAG_W,
    localparam int LVL_W      = $clog2(META_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  meta_valid,
    output logic                  meta_ready,
    input  logic [META_WIDTH-1:0] meta_in,
    input  logic                  send_en,
    input  logic [1:0]            mode,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    output logic [DATA_WIDTH-1:0] pkt_data,
    output logic                  pkt_sop,
    output logic                  pkt_eop,
    output logic [LVL_W-1:0]      fifo_level,
    output logic [31:0]           pkt_count
);

    typedef struct packed {
        logic [PORT_W-1:0] src;
        logic [PORT_W-1:0] dst;
        logic [LEN_W-1:0]  len;
        logic [TAG_W-1:0]  tag;
    } meta_t;

    localparam logic [LEN_W+3:0] HDR_LAST = (LEN_W+4)'(HDR_WORDS - 1);

    state_t                r_state;
    meta_t                 r_meta;
    mode_t                 r_mode;
    logic [63:0]           r_ts;
    logic [63:0]           r_ts_lat;
    logic [LEN_W+3:0]      r_word_idx;
    logic [31:0]           r_lfsr;
    logic                  r_valid;
    logic                  r_sop;
    logic                  r_eop;
    logic [DATA_WIDTH-1:0] r_data;
    logic [31:0]           r_pkt_count;

    logic [META_WIDTH-1:0] w_fifo_data;
    logic                  w_empty;
    logic                  w_pop;
    meta_t                 w_cur_meta;
    logic [63:0]           w_cur_ts;
    logic [47:0]           w_dmac;
    logic [47:0]           w_smac;
    logic [LEN_W:0]        w_nblk;
    logic [15:0]           w_len_bytes;
    logic [LEN_W+3:0]      w_last;
    logic [LEN_W+3:0]      w_idx_inc;
    logic [2:0]            w_hdr_sel;
    logic [31:0]           w_hdr_word;
    logic [31:0]           w_pay_idx;
    logic [31:0]           w_lfsr_cur;
    logic [31:0]           w_pay_word;
    logic                  w_accept;
    logic                  w_is_last;
    logic                  w_start;

    // In LOAD the descriptor is only on the RAM read port; afterwards it is latched.
    assign w_cur_meta = (r_state == LOAD) ? meta_t'(w_fifo_data) : r_meta;
    assign w_cur_ts   = (r_state == LOAD) ? r_ts : r_ts_lat;

    // len==0 encodes 2^LEN_W blocks, which is exactly the carry bit set.
    assign w_nblk      = {(w_cur_meta.len == '0), w_cur_meta.len};
    assign w_len_bytes = 16'({w_nblk, 5'b0_0000});
    assign w_last      = {w_nblk, 3'b000} - 1'b1;

    assign w_accept  = r_valid && pkt_ready;
    assign w_idx_inc = r_word_idx + 1'b1;
    assign w_is_last = (r_word_idx == w_last);
    assign w_start   = !w_empty && send_en;
    assign w_pop     = w_start &&
                       ((r_state == IDLE) ||
                        ((r_state == PAYLOAD) && w_accept && w_is_last));

    assign w_hdr_sel  = (r_state == LOAD) ? 3'd0 : w_idx_inc[2:0];
    assign w_pay_idx  = 32'(w_idx_inc) - 32'(HDR_WORDS);
    assign w_lfsr_cur = (r_state == HEADER) ? LFSR_SEED : r_lfsr;

    // NOTE: each always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_hdr_word = w_smac[31:0];
        case (w_hdr_sel)
            3'd0:    w_hdr_word = {w_len_bytes, w_dmac[47:32]};
            3'd1:    w_hdr_word = w_dmac[31:0];
            3'd2:    w_hdr_word = w_cur_ts[63:32];
            3'd3:    w_hdr_word = w_cur_ts[31:0];
            3'd4:    w_hdr_word = {16'h0000, w_smac[47:32]};
            default: w_hdr_word = w_smac[31:0];
        endcase
    end

    always_comb begin
        w_pay_word = '1;
        case (r_mode)
            MODE_INCR: w_pay_word = w_pay_idx;
            MODE_LFSR: w_pay_word = w_lfsr_cur;
            MODE_TAG:  w_pay_word = {16'(w_cur_meta.tag), 16'(w_cur_meta.tag)};
            default:   w_pay_word = '1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_meta      <= '0;
            r_mode      <= MODE_ONES;
            r_ts        <= '0;
            r_ts_lat    <= '0;
            r_word_idx  <= '0;
            r_lfsr      <= LFSR_SEED;
            r_valid     <= 1'b0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_data      <= '0;
            r_pkt_count <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_meta     <= w_cur_meta;
                    r_ts_lat   <= r_ts;
                    r_mode     <= mode_t'(mode);
                    r_word_idx <= '0;
                    r_valid    <= 1'b1;
                    r_sop      <= 1'b1;
                    r_eop      <= 1'b0;
                    r_data     <= w_hdr_word;
                    r_state    <= HEADER;
                end
                HEADER: begin
                    if (w_accept) begin
                        r_word_idx <= w_idx_inc;
                        r_sop      <= 1'b0;
                        if (r_word_idx == HDR_LAST) begin
                            r_data  <= w_pay_word;
                            r_lfsr  <= lfsr_next(w_lfsr_cur);
                            r_eop   <= (w_idx_inc == w_last);
                            r_state <= PAYLOAD;
                        end else begin
                            r_data <= w_hdr_word;
                        end
                    end
                end
                PAYLOAD: begin
                    if (w_accept) begin
                        if (w_is_last) begin
                            r_valid     <= 1'b0;
                            r_eop       <= 1'b0;
                            r_pkt_count <= r_pkt_count + 1'b1;
                            r_state     <= w_start ? LOAD : IDLE;
                        end else begin
                            r_word_idx <= w_idx_inc;
                            r_data     <= w_pay_word;
                            r_lfsr     <= lfsr_next(w_lfsr_cur);
                            r_eop      <= (w_idx_inc == w_last);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    meta_fifo #(
        .WIDTH (META_WIDTH),
        .DEPTH (META_DEPTH)
    ) u_meta_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (meta_valid),
        .i_data  (meta_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_ready (meta_ready),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    port_to_mac #(.PORT_W(PORT_W)) u_dmac (
        .i_port (w_cur_meta.dst),
        .o_mac  (w_dmac)
    );

    port_to_mac #(.PORT_W(PORT_W)) u_smac (
        .i_port (w_cur_meta.src),
        .o_mac  (w_smac)
    );

    assign pkt_valid = r_valid;
    assign pkt_sop   = r_sop;
    assign pkt_eop   = r_eop;
    assign pkt_data  = r_data;
    assign pkt_count = r_pkt_count;

endmodule
